// File: rtl/coherent_acc_buffer_pkg.sv
// Shared definitions for the coherent accumulation buffer: cor_index field layout,
// bank size, default widths and the signed saturating adder.
package coherent_acc_buffer_pkg;

    localparam int COR_IDX_MSB   = 4;
    localparam int COR_IDX_LSB   = 2;
    localparam int OW_BIT        = 1;
    localparam int NEW_BIT       = 0;
    localparam int NUM_COR       = 8;
    localparam int COR_W         = COR_IDX_MSB - COR_IDX_LSB + 1;
    localparam int CNT_W         = 5;
    localparam int DEFAULT_ACC_W = 21;
    localparam int SAT_W         = 32;

    typedef logic signed [SAT_W-1:0] sat_word_t;

    // Adds two sign-extended operands and clamps to the signed range of a w-bit word (w <= SAT_W).
    function automatic sat_word_t sat_add(input sat_word_t a, input sat_word_t b, input int unsigned w);
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi  = ((SAT_W+1)'(1) << (w - 1)) - (SAT_W+1)'(1);
        lo  = ~hi;
        if (sum > hi) begin
            return hi[SAT_W-1:0];
        end else if (sum < lo) begin
            return lo[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/coherent_acc_buffer_if.sv
// Bus between the correlator dumping stage, the accumulation buffer and the
// measurement stage that drains completed coherent results.
interface coherent_acc_buffer_if #(
    parameter int ACC_W      = 21,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Dump side has no backpressure: coherent_sum_valid is a one-cycle strobe taken every cycle.
    // Result side: an entry transfers on each clk edge where out_valid & out_ready; out_valid
    // never depends on out_ready, and the head entry holds stable until it is accepted.
    logic                    acc_clear;
    logic [4:0]              coherent_number;
    logic                    coherent_sum_valid;
    logic [4:0]              cor_index;
    logic signed [15:0]      i_coherent_sum;
    logic signed [15:0]      q_coherent_sum;
    logic                    out_valid;
    logic                    out_ready;
    logic [2:0]              out_cor;
    logic                    out_overwrite;
    logic signed [ACC_W-1:0] out_i;
    logic signed [ACC_W-1:0] out_q;
    logic [LVL_W-1:0]        fifo_level;
    logic                    fifo_overflow;

    modport master (
        output acc_clear, coherent_number, coherent_sum_valid, cor_index,
               i_coherent_sum, q_coherent_sum, out_ready,
        input  out_valid, out_cor, out_overwrite, out_i, out_q, fifo_level, fifo_overflow
    );

    modport slave (
        input  acc_clear, coherent_number, coherent_sum_valid, cor_index,
               i_coherent_sum, q_coherent_sum, out_ready,
        output out_valid, out_cor, out_overwrite, out_i, out_q, fifo_level, fifo_overflow
    );

endinterface

// File: rtl/coherent_acc_buffer_acc_result_fifo.sv
// Synchronous FIFO for completed coherent results; the head entry is held in a
// register so the consumer sees flop outputs.
module acc_result_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic [WIDTH-1:0] head_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [WIDTH-1:0] head_q;
    logic             push_en;
    logic             pop_en;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign pop_en  = pop_i & ~empty_o;
    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign push_en = push_i & (~full_o | pop_en);
    assign level_o = level_q;
    assign head_o  = head_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_q + LVL_W'(push_en) - LVL_W'(pop_en);
            // Next head is the second stored entry, or the incoming one when nothing else remains.
            if (pop_en && (level_q > LVL_W'(1))) begin
                head_q <= mem_q[rd_ptr_q + PTR_W'(1)];
            end else if (push_en && (empty_o || (pop_en && (level_q == LVL_W'(1))))) begin
                head_q <= push_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/coherent_acc_buffer.sv
// Per-correlator coherent accumulation over coherent_number dumps; completed
// periods are queued as {index, overwrite, I, Q} for the measurement stage.
module coherent_acc_buffer
    import coherent_acc_buffer_pkg::*;
#(
    parameter int ACC_W      = DEFAULT_ACC_W,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_b,
    coherent_acc_buffer_if.slave bus
);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = COR_W + 1 + 2 * ACC_W;

    logic signed [ACC_W-1:0] acc_i_q [NUM_COR];
    logic signed [ACC_W-1:0] acc_q_q [NUM_COR];
    logic [CNT_W-1:0]        cnt_q   [NUM_COR];
    logic [NUM_COR-1:0]      ow_q;
    logic                    fifo_overflow_q;

    logic [COR_W-1:0]        k;
    logic                    first_sum;
    sat_word_t               base_i;
    sat_word_t               base_q;
    sat_word_t               sum_i_w;
    sat_word_t               sum_q_w;
    logic signed [ACC_W-1:0] sum_i_d;
    logic signed [ACC_W-1:0] sum_q_d;
    logic [CNT_W:0]          cnt_d;
    logic                    ow_d;
    logic [CNT_W:0]          period_len;
    logic                    done;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ENTRY_W-1:0]      push_data;
    logic [ENTRY_W-1:0]      head;
    logic [LVL_W-1:0]        level;

    assign k         = bus.cor_index[COR_IDX_MSB:COR_IDX_LSB];
    assign first_sum = bus.cor_index[NEW_BIT];

    // Single-cycle read-modify-write of entry k; a first-sum dump ignores whatever was stored.
    always_comb begin
        base_i     = first_sum ? '0 : sat_word_t'(acc_i_q[k]);
        base_q     = first_sum ? '0 : sat_word_t'(acc_q_q[k]);
        sum_i_w    = sat_add(base_i, sat_word_t'(bus.i_coherent_sum), ACC_W);
        sum_q_w    = sat_add(base_q, sat_word_t'(bus.q_coherent_sum), ACC_W);
        sum_i_d    = sum_i_w[ACC_W-1:0];
        sum_q_d    = sum_q_w[ACC_W-1:0];
        cnt_d      = first_sum ? (CNT_W+1)'(1) : ({1'b0, cnt_q[k]} + (CNT_W+1)'(1));
        ow_d       = bus.cor_index[OW_BIT] | (~first_sum & ow_q[k]);
        period_len = (bus.coherent_number == '0) ? (CNT_W+1)'(1) : {1'b0, bus.coherent_number};
        done       = (cnt_d >= period_len);
        push       = bus.coherent_sum_valid & ~bus.acc_clear & done;
        pop        = ~fifo_empty & bus.out_ready;
        push_data  = {k, ow_d, sum_i_d, sum_q_d};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int n = 0; n < NUM_COR; n++) begin
                acc_i_q[n] <= '0;
                acc_q_q[n] <= '0;
                cnt_q[n]   <= '0;
            end
            ow_q            <= '0;
            fifo_overflow_q <= 1'b0;
        end else if (bus.acc_clear) begin
            // A dump arriving with the clear is discarded along with the bank contents.
            for (int n = 0; n < NUM_COR; n++) begin
                acc_i_q[n] <= '0;
                acc_q_q[n] <= '0;
                cnt_q[n]   <= '0;
            end
            ow_q            <= '0;
            fifo_overflow_q <= 1'b0;
        end else begin
            if (bus.coherent_sum_valid) begin
                if (done) begin
                    acc_i_q[k] <= '0;
                    acc_q_q[k] <= '0;
                    cnt_q[k]   <= '0;
                    ow_q[k]    <= 1'b0;
                end else begin
                    acc_i_q[k] <= sum_i_d;
                    acc_q_q[k] <= sum_q_d;
                    cnt_q[k]   <= cnt_d[CNT_W-1:0];
                    ow_q[k]    <= ow_d;
                end
            end
            if (push && fifo_full && !pop) begin
                fifo_overflow_q <= 1'b1;
            end
        end
    end

    acc_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_b       (rst_b),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level),
        .head_o      (head)
    );

    assign bus.out_valid     = ~fifo_empty;
    assign bus.out_cor       = head[ENTRY_W-1 -: COR_W];
    assign bus.out_overwrite = head[2*ACC_W];
    assign bus.out_i         = head[2*ACC_W-1 -: ACC_W];
    assign bus.out_q         = head[ACC_W-1:0];
    assign bus.fifo_level    = level;
    assign bus.fifo_overflow = fifo_overflow_q;

endmodule
